// File: rtl/bus_slave_sel.sv
// Registered slave-select decoder: latches a one-hot select on start and holds it until the
// addressed slave reports done, flagging unmapped IDs and hung transactions.
module bus_slave_sel #(
    parameter int unsigned N_SLAVES = 3,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                start,
    input  logic [SEL_W-1:0]    sel,
    input  logic [N_SLAVES-1:0] s_done,
    output logic [N_SLAVES-1:0] sel_out,
    output logic                busy,
    output logic                err,
    output logic                timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(N_SLAVES);

    typedef enum logic [1:0] {StIdle, StActive, StErr} state_e;

    state_e              r_state;
    logic [N_SLAVES-1:0] r_sel_out;
    logic                r_busy;
    logic                r_err;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_cnt;

    logic [N_SLAVES-1:0] w_onehot;
    logic                w_sel_ok;
    logic                w_done;

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            w_onehot[i] = (sel == SEL_W'(i));
        end
    end

    assign w_sel_ok = ({1'b0, sel} < SEL_LIMIT);
    // Only the done strobe of the latched slave can end the transaction.
    assign w_done   = |(s_done & r_sel_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_sel_out <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start && en) begin
                        if (w_sel_ok) begin
                            r_state   <= StActive;
                            r_sel_out <= w_onehot;
                            r_busy    <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_state <= StErr;
                            r_err   <= 1'b1;
                        end
                    end
                end
                StActive: begin
                    if (w_done) begin
                        r_state   <= StIdle;
                        r_sel_out <= '0;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= StIdle;
                        r_sel_out <= '0;
                        r_busy    <= 1'b0;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StErr: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state   <= StIdle;
                    r_sel_out <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign sel_out = r_sel_out;
    assign busy    = r_busy;
    assign err     = r_err;
    assign timeout = r_timeout;

endmodule
